// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO-mapped 8N1 UART transmitter with TX FIFO
// Optional feature macro: MMIO_UART_TX_IRQ_EN (adds irq output and CTRL.irq_en)
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_data,
  output logic [31:0] bus_rd_data,
  input  logic        bus_cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Registers
  logic          ovf_q, ovf_d;
  logic [15:0]   baud_div_q, baud_div_d;
`ifdef MMIO_UART_TX_IRQ_EN
  logic          irq_en_q, irq_en_d;
  logic          irq_q;
`endif

  // Transmitter
  state_t        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic [15:0]   timer_q;
  logic          tx_q;

  // Bus decode
  logic          sel;
  logic [1:0]    reg_idx;
  logic          wr_en;
  logic          wr_txdata, wr_status, wr_baud, wr_ctrl;

  // FIFO status
  logic          full, empty, push, pop, busy;
  logic [7:0]    head;

  // Read path
  logic [8:0]    count_ext;
  logic [31:0]   status_val;
  logic [31:0]   ctrl_val;
  logic [31:0]   rd_val;
  logic          unused_ok;

  assign sel       = bus_cs & (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = bus_addr[3:2];
  assign wr_en     = sel & bus_wr;
  assign wr_txdata = wr_en & (reg_idx == 2'd0);
  assign wr_status = wr_en & (reg_idx == 2'd1);
  assign wr_baud   = wr_en & (reg_idx == 2'd2);
  assign wr_ctrl   = wr_en & (reg_idx == 2'd3);

  // full is the pre-edge value, so a push into a full FIFO is dropped even if a pop happens on the same edge
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_txdata & ~full;
  assign pop   = (state_q == S_IDLE) & ~empty;
  assign busy  = (state_q != S_IDLE);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for FIFO pointers, count and the software-visible registers
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    baud_div_d = baud_div_q;
`ifdef MMIO_UART_TX_IRQ_EN
    irq_en_d   = irq_en_q;
`endif

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // TXDATA and STATUS are different registers, so set and clear never collide
    if (wr_status && bus_wr_data[3]) begin
      ovf_d = 1'b0;
    end
    if (wr_txdata && full) begin
      ovf_d = 1'b1;
    end

    if (wr_baud) begin
      baud_div_d = bus_wr_data[15:0];
    end
`ifdef MMIO_UART_TX_IRQ_EN
    if (wr_ctrl) begin
      irq_en_d = bus_wr_data[0];
    end
`endif
  end

  // Register update for FIFO bookkeeping and configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      baud_div_q <= DEFAULT_DIV;
`ifdef MMIO_UART_TX_IRQ_EN
      irq_en_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      baud_div_q <= baud_div_d;
`ifdef MMIO_UART_TX_IRQ_EN
      irq_en_q   <= irq_en_d;
`endif
    end
  end

  // FIFO data array; contents are don't-care while the entry is not counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus_wr_data[7:0];
    end
  end

  // Frame sequencer: tx is registered and always carries the bit of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q <= head;
            timer_q <= baud_div_q;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_q == 16'd0) begin
            timer_q   <= baud_div_q;
            bit_cnt_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_DATA: begin
          if (timer_q == 16'd0) begin
            timer_q <= baud_div_q;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (timer_q == 16'd0) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MMIO_UART_TX_IRQ_EN
  // Level interrupt: transmitter fully drained and idle
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & empty & ~busy;
    end
  end

  assign irq      = irq_q;
  assign ctrl_val = {31'h0, irq_en_q};
`else
  assign ctrl_val = 32'h0;
`endif

  assign count_ext  = 9'(count_q);
  assign status_val = {16'h0, count_ext[7:0], 4'h0, ovf_q, busy, empty, full};

  // Combinational read mux; reads never change state
  always_comb begin
    rd_val = 32'h0;
    case (reg_idx)
      2'd0:    rd_val = 32'h0;
      2'd1:    rd_val = status_val;
      2'd2:    rd_val = {16'h0, baud_div_q};
      2'd3:    rd_val = ctrl_val;
      default: rd_val = 32'h0;
    endcase
    bus_rd_data = (sel & bus_rd) ? rd_val : 32'h0;
  end

  assign tx = tx_q;

  assign unused_ok = ^{bus_addr[1:0], bus_wr_data[31:16], count_ext[8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed bench for mmio_uart_tx
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int BITLEN = 4;
`ifdef MMIO_UART_TX_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h1;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wr_data = '0;
  logic [31:0] bus_rd_data;
  logic        bus_cs = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mmio_uart_tx dut (
    .clk         (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_cs      (bus_cs),
    .bus_wr      (bus_wr),
    .bus_rd      (bus_rd),
    .tx          (tx)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        cs;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic cs);
    bus_cs = cs; bus_wr = 1'b1; bus_addr = a; bus_wr_data = d;
    tick;
    bus_cs = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic cs, output logic [31:0] d);
    bus_cs = cs; bus_rd = 1'b1; bus_addr = a;
    #1;
    d = bus_rd_data;
    bus_cs = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, 1'b1, d);
    check(name, d, exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] d;
    logic done;
    done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      bus_read(BASE + 32'h4, 1'b1, d);
      if (!d[2]) begin
        done = 1'b1;
        break;
      end
      tick;
    end
    check(name, {31'h0, done}, 32'h1);
  endtask

  task automatic rx_byte(input string name, input logic [7:0] exp);
    logic       seen;
    logic [7:0] b;
    int         cur;
    int         target;
    seen = 1'b0;
    b = '0;
    for (int t = 0; t < 400; t++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    check({name, "_start_seen"}, {31'h0, seen}, 32'h1);
    if (seen) begin
      cur = 0;
      for (int i = 0; i < 8; i++) begin
        target = BITLEN * (1 + i) + BITLEN / 2;
        repeat (target - cur) tick;
        cur = target;
        b[i] = tx;
      end
      check({name, "_data"}, {24'h0, b}, {24'h0, exp});
      target = BITLEN * 9 + BITLEN / 2;
      repeat (target - cur) tick;
      check({name, "_stop"}, {31'h0, tx}, 32'h1);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    logic        exp_tx;
    int          k;

    vecs[0]  = '{1'b1, 1'b0, BASE + 32'h4,  32'h0000_0002};
    vecs[1]  = '{1'b1, 1'b0, BASE + 32'h8,  32'h0000_0363};
    vecs[2]  = '{1'b1, 1'b0, BASE + 32'h0,  32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, BASE + 32'hC,  32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b1, BASE + 32'h8,  32'hABCD_1234};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h8,  32'h0000_1234};
    vecs[6]  = '{1'b0, 1'b1, BASE + 32'h8,  32'h0000_0005};
    vecs[7]  = '{1'b1, 1'b0, BASE + 32'h8,  32'h0000_1234};
    vecs[8]  = '{1'b1, 1'b1, BASE + 32'h18, 32'h0000_0006};
    vecs[9]  = '{1'b1, 1'b0, BASE + 32'h8,  32'h0000_1234};
    vecs[10] = '{1'b0, 1'b0, BASE + 32'h8,  32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, BASE + 32'h18, 32'h0000_0000};
    vecs[12] = '{1'b1, 1'b0, 32'h2000_0008, 32'h0000_0000};
    vecs[13] = '{1'b1, 1'b1, BASE + 32'hC,  32'h0000_0001};
    vecs[14] = '{1'b1, 1'b0, BASE + 32'hC,  CTRL_RB};
    vecs[15] = '{1'b1, 1'b1, BASE + 32'hC,  32'h0000_0000};
    vecs[16] = '{1'b1, 1'b1, BASE + 32'h8,  32'h0000_0003};
    vecs[17] = '{1'b1, 1'b0, BASE + 32'hB,  32'h0000_0003};
    vecs[18] = '{1'b1, 1'b1, BASE + 32'h4,  32'hFFFF_FFFF};
    vecs[19] = '{1'b1, 1'b0, BASE + 32'h4,  32'h0000_0002};
    vecs[20] = '{1'b0, 1'b1, BASE + 32'h0,  32'h0000_0099};
    vecs[21] = '{1'b1, 1'b0, BASE + 32'h4,  32'h0000_0002};

    repeat (3) tick;
    reset = 1'b0;
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_rd_data_idle", bus_rd_data, 32'h0);
`ifdef MMIO_UART_TX_IRQ_EN
    check("reset_irq", {31'h0, irq}, 32'h0);
`endif

    // Register map vectors
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data, vecs[i].cs);
      end else begin
        bus_read(vecs[i].addr, vecs[i].cs, d);
        check($sformatf("vec%0d", i), d, vecs[i].data);
        tick;
      end
    end

    // Single frame 0x55 at baud_div = 3
    pat = 8'h55;
    bus_write(BASE, 32'h55, 1'b1);
    check("a_tx_before_pop", {31'h0, tx}, 32'h1);
    check_reg("a_status_queued", BASE + 32'h4, 32'h0000_0100);
    tick;
    for (int c = 0; c < 40; c++) begin
      k = c / BITLEN;
      if (k == 0) exp_tx = 1'b0;
      else if (k == 9) exp_tx = 1'b1;
      else exp_tx = pat[k-1];
      check($sformatf("a_tx_c%0d", c), {31'h0, tx}, {31'h0, exp_tx});
      bus_read(BASE + 32'h4, 1'b1, d);
      check($sformatf("a_busy_c%0d", c), {31'h0, d[2]}, 32'h1);
      tick;
    end
    check_reg("a_status_done", BASE + 32'h4, 32'h0000_0002);
    check("a_tx_idle", {31'h0, tx}, 32'h1);

    // Ten back-to-back pushes: one popped, eight fill the FIFO, last one overflows
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = BASE;
    for (int i = 0; i < 10; i++) begin
      bus_wr_data = 32'hA0 + 32'(i);
      tick;
    end
    bus_cs = 1'b0; bus_wr = 1'b0;
    check_reg("b_status_full_ovf", BASE + 32'h4, 32'h0000_080D);
    bus_write(BASE + 32'h4, 32'h7, 1'b1);
    check_reg("b_status_w1c_zero", BASE + 32'h4, 32'h0000_080D);
    bus_write(BASE + 32'h4, 32'h8, 1'b1);
    check_reg("b_status_w1c", BASE + 32'h4, 32'h0000_0805);
    wait_idle("b_wait_frame0");
    for (int i = 1; i < 9; i++) begin
      rx_byte($sformatf("b_byte%0d", i), 8'hA0 + 8'(i));
    end
    wait_idle("b_wait_last");
    check_reg("b_status_drained", BASE + 32'h4, 32'h0000_0002);

    // Push and pop on the same edge with count = 3
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = BASE;
    bus_wr_data = 32'h3C; tick;
    bus_wr_data = 32'hC3; tick;
    bus_wr_data = 32'h5A; tick;
    bus_wr_data = 32'h96; tick;
    bus_cs = 1'b0; bus_wr = 1'b0;
    wait_idle("c_wait_frame0");
    check_reg("c_status_count3", BASE + 32'h4, 32'h0000_0300);
    bus_write(BASE, 32'h81, 1'b1);
    check_reg("c_status_pushpop", BASE + 32'h4, 32'h0000_0304);
    rx_byte("c_byte1", 8'hC3);
    rx_byte("c_byte2", 8'h5A);
    rx_byte("c_byte3", 8'h96);
    rx_byte("c_byte4", 8'h81);
    wait_idle("c_wait_last");

    // Reset in the middle of data bit 4
    bus_write(BASE, 32'h0F, 1'b1);
    bus_write(BASE, 32'h77, 1'b1);
    repeat (21) tick;
    check("d_tx_bit4", {31'h0, tx}, 32'h0);
    check_reg("d_status_mid", BASE + 32'h4, 32'h0000_0104);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("d_tx_after_reset", {31'h0, tx}, 32'h1);
    check_reg("d_status_after_reset", BASE + 32'h4, 32'h0000_0002);
    check_reg("d_baud_after_reset", BASE + 32'h8, 32'h0000_0363);
    repeat (5) tick;
    check("d_tx_stays_idle", {31'h0, tx}, 32'h1);
    check_reg("d_status_stays_idle", BASE + 32'h4, 32'h0000_0002);

`ifdef MMIO_UART_TX_IRQ_EN
    // Interrupt on transmitter drain
    bus_write(BASE + 32'h8, 32'h3, 1'b1);
    check("e_irq_disabled", {31'h0, irq}, 32'h0);
    bus_write(BASE + 32'hC, 32'h1, 1'b1);
    tick;
    check("e_irq_idle_enabled", {31'h0, irq}, 32'h1);
    bus_write(BASE, 32'hA5, 1'b1);
    tick;
    for (int c = 0; c < 40; c++) begin
      check($sformatf("e_irq_busy_c%0d", c), {31'h0, irq}, 32'h0);
      tick;
    end
    check_reg("e_status_idle", BASE + 32'h4, 32'h0000_0002);
    check("e_irq_stop_end", {31'h0, irq}, 32'h0);
    tick;
    check("e_irq_asserted", {31'h0, irq}, 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
